// File: rtl/reg_file_dualwr.sv
// RV32I architectural register file: two combinational read ports, two write ports
// (port B wins on collision), x0 tied to zero, optional bypass, a0 tap, scrub engine.
module reg_file_dualwr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int A0_IDX     = 10,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A4,
  input  logic [DATA_WIDTH-1:0] WD4,
  input  logic                  WE4,
  input  logic                  clr,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR   = ADDR_WIDTH'(A0_IDX);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   cnt_r, cnt_s;
  logic                    busy_r, busy_s;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic [DATA_WIDTH-1:0]   a0_r;
  logic                    wr_a_s, wr_b_s;

  // Port A is suppressed when port B targets the same register in the same cycle.
  assign wr_b_s = !busy_r && WE4 && (A4 != ZERO_ADDR);
  assign wr_a_s = !busy_r && WE3 && (A3 != ZERO_ADDR) && !(WE4 && (A4 == A3));

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  scrubbing,
    input logic                  we_a, input logic [ADDR_WIDTH-1:0] addr_a, input logic [DATA_WIDTH-1:0] wd_a,
    input logic                  we_b, input logic [ADDR_WIDTH-1:0] addr_b, input logic [DATA_WIDTH-1:0] wd_b
  );
    logic [DATA_WIDTH-1:0] r;
    if (addr == ZERO_ADDR) begin
      r = '0;
    end else if ((BYPASS != 0) && !scrubbing && we_b && (addr_b == addr)) begin
      r = wd_b;
    end else if ((BYPASS != 0) && !scrubbing && we_a && (addr_a == addr)) begin
      r = wd_a;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  assign RD1  = read_port(A1, mem_r[A1], busy_r, WE3, A3, WD3, WE4, A4, WD4);
  assign RD2  = read_port(A2, mem_r[A2], busy_r, WE3, A3, WD3, WE4, A4, WD4);
  assign busy = busy_r;
  assign a0   = a0_r;

  // Scrub FSM next-state: IDLE waits for clr, CLEAR walks entries 1..DEPTH-1.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (clr) begin
          state_s = CLEAR;
          cnt_s   = ONE_ADDR;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      CLEAR: begin
        cnt_s = cnt_r + ONE_ADDR;
        if (cnt_r == LAST_ADDR) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          state_s = CLEAR;
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Scrub FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
    end
  end

  // Register array and a0 mirror; a0 tracks the entry at A0_IDX edge for edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      a0_r <= '0;
    end else if (busy_r) begin
      mem_r[cnt_r] <= '0;
      if (cnt_r == A0_ADDR) begin
        a0_r <= '0;
      end else begin
        a0_r <= a0_r;
      end
    end else begin
      if (wr_a_s) begin
        mem_r[A3] <= WD3;
      end
      if (wr_b_s) begin
        mem_r[A4] <= WD4;
      end
      if (wr_b_s && (A4 == A0_ADDR)) begin
        a0_r <= WD4;
      end else if (wr_a_s && (A3 == A0_ADDR)) begin
        a0_r <= WD3;
      end else begin
        a0_r <= a0_r;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_dualwr.sv
// Randomised self-checking bench for reg_file_dualwr: array-level reference model plus
// directed scenarios for reset, x0, collision/bypass, a0 tap and scrub.
module tb_reg_file_dualwr;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int A0I   = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] A1, A2, A3, A4;
  logic [DW-1:0] WD3, WD4;
  logic          WE3, WE4, clr;
  logic [DW-1:0] RD1, RD2, a0, nb_rd1, nb_rd2, nb_a0;
  logic          busy, nb_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic seen_busy;

  always #5 clk = ~clk;

  reg_file_dualwr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A0_IDX(A0I), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .A3(A3), .WD3(WD3), .WE3(WE3), .A4(A4), .WD4(WD4), .WE4(WE4),
    .clr(clr), .busy(busy), .a0(a0));

  reg_file_dualwr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A0_IDX(A0I), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(nb_rd1), .RD2(nb_rd2),
    .A3(A3), .WD3(WD3), .WE3(WE3), .A4(A4), .WD4(WD4), .WE4(WE4),
    .clr(clr), .busy(nb_busy), .a0(nb_a0));

  // Reference model: architectural array, scrub flag and index of next entry to clear.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_busy;
  int            m_pos;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_busy <= 1'b0;
      m_pos  <= 0;
    end else if (m_busy) begin
      m_mem[m_pos] <= '0;
      m_busy <= (m_pos < DEPTH - 1);
      m_pos  <= m_pos + 1;
    end else begin
      if (WE3 && A3 != 5'd0) m_mem[A3] <= WD3;
      if (WE4 && A4 != 5'd0) m_mem[A4] <= WD4;
      if (clr) begin
        m_busy <= 1'b1;
        m_pos  <= 1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] addr, input bit byp);
    if (addr == 5'd0) return 32'd0;
    if (byp && !m_busy && WE4 && A4 == addr) return WD4;
    if (byp && !m_busy && WE3 && A3 == addr) return WD3;
    return m_mem[addr];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rd1",    RD1,                  exp_rd(A1, 1'b1));
    check("rd2",    RD2,                  exp_rd(A2, 1'b1));
    check("busy",   {31'd0, busy},        {31'd0, m_busy});
    check("a0",     a0,                   m_mem[A0I]);
    check("nb_rd1", nb_rd1,               exp_rd(A1, 1'b0));
    check("nb_rd2", nb_rd2,               exp_rd(A2, 1'b0));
    check("nb_busy",{31'd0, nb_busy},     {31'd0, m_busy});
    check("nb_a0",  nb_a0,                m_mem[A0I]);
  endtask

  task automatic tick();
    @(negedge clk);
    seen_busy = busy;
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE3 = 1'b0; WE4 = 1'b0; clr = 1'b0;
    A3 = 5'd0; A4 = 5'd0; WD3 = 32'd0; WD4 = 32'd0;
  endtask

  task automatic count_scrub(input string name);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      if (k == 3) begin WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h0000_0BAD; end
      if (k == 5) clr = 1'b1;
      tick();
      if (seen_busy) cnt++;
      else if (cnt > 0) break;
    end
    idle_inputs();
    check(name, cnt, 32'd31);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    A1 = 5'd0; A2 = 5'd0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: asynchronous reset clears contents with no clock edge
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h0000_DEAD; A1 = 5'd5;
    tick();
    idle_inputs();
    #1 check("x5_written", RD1, 32'h0000_DEAD);
    #1 rst_n = 1'b0;
    #1;
    check("reset_rd_x5", RD1, 32'd0);
    check("reset_a0",    a0,  32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: x0 ignores writes
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF_FFFF; A1 = 5'd0;
    #1 check("x0_same_cycle", RD1, 32'd0);
    tick();
    idle_inputs();
    #1 check("x0_after", RD1, 32'd0);

    // 3: collision, port B wins; BYPASS=0 shows old value in that cycle
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h0000_0055;
    tick();
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h0000_0011;
    WE4 = 1'b1; A4 = 5'd7; WD4 = 32'h0000_0022; A1 = 5'd7;
    #1;
    check("coll_bypass", RD1,    32'h0000_0022);
    check("coll_nobyp",  nb_rd1, 32'h0000_0055);
    tick();
    idle_inputs();
    #1;
    check("coll_after",    RD1,    32'h0000_0022);
    check("coll_after_nb", nb_rd1, 32'h0000_0022);

    // 4: a0 tap follows x10 only
    WE3 = 1'b1; A3 = 5'd10; WD3 = 32'h0000_1234;
    tick();
    check("a0_x10", a0, 32'h0000_1234);
    WE3 = 1'b1; A3 = 5'd11; WD3 = 32'h0000_0005;
    tick();
    idle_inputs();
    check("a0_hold", a0, 32'h0000_1234);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      WE3 = 1'($urandom_range(0, 1));
      WE4 = 1'($urandom_range(0, 1));
      A3  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(9, 11)) : 5'($urandom);
      A4  = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom);
      A1  = ($urandom_range(0, 1) == 0) ? A3 : 5'($urandom);
      A2  = ($urandom_range(0, 1) == 0) ? A4 : 5'($urandom);
      WD3 = $urandom;
      WD4 = $urandom;
      clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle_inputs();
    repeat (35) tick();

    // 5: load every register, scrub, then everything reads zero
    for (int i = 1; i < DEPTH; i += 2) begin
      WE3 = 1'b1; A3 = 5'(i);     WD3 = (i * 32'h0101_0101) ^ 32'hA500_0000;
      WE4 = (i + 1 < DEPTH);
      A4  = 5'(i + 1);            WD4 = ((i + 1) * 32'h0101_0101) ^ 32'hA500_0000;
      tick();
    end
    idle_inputs();
    check("a0_loaded", a0, 32'hAF0A_0A0A);
    clr = 1'b1;
    tick();
    count_scrub("scrub_len");
    A1 = 5'd3;
    #1 check("scrub_drop_wr", RD1, 32'd0);
    check("scrub_a0", a0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      A1 = 5'(i); A2 = 5'(DEPTH - 1 - i);
      #1 check("scrub_zero", RD1, 32'd0);
      tick();
    end

    // 6: reset part-way through a scrub, then a full-length rerun
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    #1 rst_n = 1'b0;
    #1 check("abort_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1;
    tick();
    count_scrub("rescrub_len");
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
